// File: rtl/gfx_pkg.sv
// Shared constants for the graphics front end: frame geometry, register
// indices and the default reset image of the 10-register game bank.
package gfx_pkg;

  // Pixel address of the last pixel of a 640x480 frame.
  localparam logic [18:0] FRAME_LAST_ADDR_640x480 = 19'h4AFFF;

  // Register map of the game bank.
  localparam int P1_X       = 0;
  localparam int P1_Y       = 1;
  localparam int P2_X       = 2;
  localparam int P2_Y       = 3;
  localparam int BALL_X     = 4;
  localparam int BALL_Y     = 5;
  localparam int BALL_Z     = 6;
  localparam int SCORE_1    = 7;
  localparam int SCORE_2    = 8;
  localparam int GAME_STATE = 9;

  localparam int GFX_NUM_REGS = 10;
  localparam int GFX_DATA_W   = 16;

  // Everything starts centred on screen; depth, scores and state start at 0.
  // Register i occupies bits [i*GFX_DATA_W +: GFX_DATA_W].
  localparam logic [GFX_NUM_REGS*GFX_DATA_W-1:0] DEFAULT_RESET_VALS = {
    16'd0,    // GAME_STATE
    16'd0,    // SCORE_2
    16'd0,    // SCORE_1
    16'd0,    // BALL_Z
    16'd240,  // BALL_Y
    16'd320,  // BALL_X
    16'd240,  // P2_Y
    16'd320,  // P2_X
    16'd240,  // P1_Y
    16'd320   // P1_X
  };

endpackage

// File: rtl/gfx_frame_sync.sv
// Frame synchroniser: detects the last pixel of a frame, decides whether the
// shadow bank swaps this edge, and keeps the frame_swap pulse and frame count.
// Optional feature macro: GFX_REG_BANK_COMMIT_EN (swap only after a commit).
module gfx_frame_sync
  import gfx_pkg::*;
#(
  parameter int                    PIX_ADDR_W      = 19,
  parameter logic [PIX_ADDR_W-1:0] FRAME_LAST_ADDR = PIX_ADDR_W'(FRAME_LAST_ADDR_640x480),
  parameter int                    DATA_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  VGA_ready,
  input  logic [PIX_ADDR_W-1:0] pixel_address,
  input  logic                  commit_wr,
  output logic                  swap_now,
  output logic                  commit_pending,
  output logic                  frame_swap,
  output logic [DATA_W-1:0]     frame_count
);

  logic swap_cond;
  assign swap_cond = VGA_ready && (pixel_address == FRAME_LAST_ADDR);

`ifdef GFX_REG_BANK_COMMIT_EN
  // A commit written on the swap edge itself still counts for this frame.
  assign swap_now = swap_cond && (commit_pending || commit_wr);

  // Commit flag: set by a commit write, consumed by the swap it enables.
  always_ff @(posedge clk) begin
    if (rst)
      commit_pending <= 1'b0;
    else if (swap_now)
      commit_pending <= 1'b0;
    else if (commit_wr)
      commit_pending <= 1'b1;
  end
`else
  assign swap_now       = swap_cond;
  assign commit_pending = 1'b0;
  logic unused_commit_wr;
  assign unused_commit_wr = commit_wr;
`endif

  // Swap pulse and completed-swap counter, one cycle behind the swap edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      frame_swap  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_swap <= swap_now;
      if (swap_now)
        frame_count <= frame_count + 1'b1;  // wraps silently
    end
  end

endmodule

// File: rtl/gfx_reg_bank.sv
// CPU-facing graphics register bank with a frame-synchronous shadow copy.
// Optional feature macro: GFX_REG_BANK_COMMIT_EN (commit register at
// address NUM_REGS gates the shadow swap).
module gfx_reg_bank
  import gfx_pkg::*;
#(
  parameter int                          NUM_REGS        = 10,
  parameter int                          DATA_W          = 16,
  parameter int                          ADDR_W          = 4,
  parameter int                          PIX_ADDR_W      = 19,
  parameter logic [PIX_ADDR_W-1:0]       FRAME_LAST_ADDR = PIX_ADDR_W'(FRAME_LAST_ADDR_640x480),
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALS      = {NUM_REGS*DATA_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic [ADDR_W-1:0]            data_address,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         addr_err,
  input  logic                         VGA_ready,
  input  logic [PIX_ADDR_W-1:0]        pixel_address,
  output logic [NUM_REGS*DATA_W-1:0]   shadow_flat,
  output logic                         frame_swap,
  output logic [DATA_W-1:0]            frame_count
);

  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] live   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];

  logic              mapped;
  logic              is_commit_addr;
  logic              wr_en;
  logic              rd_en;
  logic              commit_wr;
  logic              swap_now;
  logic              commit_pending;
  logic [DATA_W-1:0] rd_mux;

  assign mapped = data_address < NUM_REGS_A;
  assign wr_en  = chipselect && !read;
  assign rd_en  = chipselect && read;

`ifdef GFX_REG_BANK_COMMIT_EN
  assign is_commit_addr = (data_address == NUM_REGS_A);
`else
  assign is_commit_addr = 1'b0;
`endif

  assign commit_wr = wr_en && is_commit_addr;

  gfx_frame_sync #(
    .PIX_ADDR_W      (PIX_ADDR_W),
    .FRAME_LAST_ADDR (FRAME_LAST_ADDR),
    .DATA_W          (DATA_W)
  ) u_frame_sync (
    .clk            (clk),
    .rst            (rst),
    .VGA_ready      (VGA_ready),
    .pixel_address  (pixel_address),
    .commit_wr      (commit_wr),
    .swap_now       (swap_now),
    .commit_pending (commit_pending),
    .frame_swap     (frame_swap),
    .frame_count    (frame_count)
  );

  // Live/shadow bank: CPU writes land in live; swap copies pre-edge live.
  always_ff @(posedge clk) begin
    // NOTE: the bank is a small flop array with a defined power-up image, so
    // it is reset element by element; a RAM-backed bank could not be.
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= RESET_VALS[i*DATA_W +: DATA_W];
        shadow[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      if (swap_now)
        for (int i = 0; i < NUM_REGS; i++)
          shadow[i] <= live[i];
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en && data_address == ADDR_W'(i))
          live[i] <= wr_data;
    end
  end

  // Read-back mux: live register, commit status, or zero for unmapped.
  always_comb begin
    // NOTE: default first so no path leaves rd_mux unassigned (no latch).
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (data_address == ADDR_W'(i))
        rd_mux = live[i];
    if (is_commit_addr)
      rd_mux = {{(DATA_W-1){1'b0}}, commit_pending};
  end

  // Registered read port and address-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      addr_err <= chipselect && !mapped && !is_commit_addr;
      if (rd_en)
        rd_data <= rd_mux;
    end
  end

  // Flatten the shadow bank for the renderers.
  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_REGS; i++)
      shadow_flat[i*DATA_W +: DATA_W] = shadow[i];
  end

endmodule

// File: tb/tb_gfx_reg_bank.sv
// Self-checking bench for gfx_reg_bank: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_gfx_reg_bank;
  import gfx_pkg::*;

  localparam int NR  = 10;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int PW  = 19;
  localparam logic [PW-1:0] LAST = FRAME_LAST_ADDR_640x480;
`ifdef GFX_REG_BANK_COMMIT_EN
  localparam bit COMMIT = 1'b1;
`else
  localparam bit COMMIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              chipselect = 1'b0;
  logic              read = 1'b0;
  logic [AW-1:0]     data_address = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              addr_err;
  logic              VGA_ready = 1'b0;
  logic [PW-1:0]     pixel_address = '0;
  logic [NR*DW-1:0]  shadow_flat;
  logic              frame_swap;
  logic [DW-1:0]     frame_count;

  gfx_reg_bank #(
    .NUM_REGS        (NR),
    .DATA_W          (DW),
    .ADDR_W          (AW),
    .PIX_ADDR_W      (PW),
    .FRAME_LAST_ADDR (LAST),
    .RESET_VALS      (DEFAULT_RESET_VALS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chipselect    (chipselect),
    .read          (read),
    .data_address  (data_address),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .addr_err      (addr_err),
    .VGA_ready     (VGA_ready),
    .pixel_address (pixel_address),
    .shadow_flat   (shadow_flat),
    .frame_swap    (frame_swap),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [NR*DW-1:0] got,
                       input logic [NR*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the register file as the CPU and renderer see it.
  logic [DW-1:0] m_live   [NR];
  logic [DW-1:0] m_shadow [NR];
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] m_count;
  bit            m_valid, m_err, m_fswap, m_pend;

  // One bus/pixel cycle: drive, clock, advance the model, compare.
  task automatic step(input bit r, input bit c, input bit rd_i,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit v, input logic [PW-1:0] p);
    bit mapped, is_commit, wr, rdacc, swap;
    logic [NR*DW-1:0] exp_flat;
    rst = r; chipselect = c; read = rd_i; data_address = a;
    wr_data = d; VGA_ready = v; pixel_address = p;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < NR; i++) begin
        m_live[i]   = DEFAULT_RESET_VALS[i*DW +: DW];
        m_shadow[i] = DEFAULT_RESET_VALS[i*DW +: DW];
      end
      m_rd_data = '0; m_valid = 0; m_err = 0; m_fswap = 0;
      m_count = '0; m_pend = 0;
    end else begin
      mapped    = (int'(a) < NR);
      is_commit = COMMIT && (int'(a) == NR);
      wr        = c && !rd_i;
      rdacc     = c && rd_i;
      swap      = (p == LAST) && v;
      if (COMMIT) swap = swap && (m_pend || (wr && is_commit));
      m_valid = rdacc;
      m_err   = c && !mapped && !is_commit;
      if (rdacc)
        m_rd_data = mapped ? m_live[a] : (is_commit ? DW'(m_pend) : '0);
      if (swap) begin
        for (int i = 0; i < NR; i++) m_shadow[i] = m_live[i];
        m_count = m_count + 1'b1;
      end
      m_fswap = swap;
      if (wr && mapped) m_live[a] = d;
      if (COMMIT) begin
        if (swap) m_pend = 0;
        else if (wr && is_commit) m_pend = 1;
      end
    end
    for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = m_shadow[i];
    check("rd_data",     NR*DW'(rd_data),     NR*DW'(m_rd_data));
    check("rd_valid",    NR*DW'(rd_valid),    NR*DW'(m_valid));
    check("addr_err",    NR*DW'(addr_err),    NR*DW'(m_err));
    check("frame_swap",  NR*DW'(frame_swap),  NR*DW'(m_fswap));
    check("frame_count", NR*DW'(frame_count), NR*DW'(m_count));
    check("shadow_flat", shadow_flat,         exp_flat);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(0, 1, 0, a, d, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, 1, 1, a, '0, 0, '0);
  endtask

  task automatic frame_end(input bit v);
    step(0, 0, 0, '0, '0, v, LAST);
  endtask

  initial begin
    // Reset image straight from the package.
    step(1, 1, 0, 4'd0, 16'hFFFF, 1, LAST);
    check("reset_shadow_p1x", NR*DW'(shadow_flat[P1_X*DW +: DW]), NR*DW'(320));
    check("reset_shadow_p1y", NR*DW'(shadow_flat[P1_Y*DW +: DW]), NR*DW'(240));
    check("reset_shadow_bz",  NR*DW'(shadow_flat[BALL_Z*DW +: DW]), NR*DW'(0));
    idle();

    // Write then read BALL_X; shadow untouched until frame end.
    wr(4'(BALL_X), 16'h0123);
    rd(4'(BALL_X));
    check("rd_ball_x", NR*DW'(rd_data), NR*DW'(16'h0123));
    check("shadow_ball_x_pre", NR*DW'(shadow_flat[BALL_X*DW +: DW]), NR*DW'(320));
    idle();

`ifdef GFX_REG_BANK_COMMIT_EN
    // No commit: frame end leaves everything alone.
    wr(4'(P1_X), 16'h0050);
    frame_end(1);
    check("nocommit_shadow_p1x", NR*DW'(shadow_flat[P1_X*DW +: DW]), NR*DW'(320));
    check("nocommit_fswap", NR*DW'(frame_swap), NR*DW'(0));
    wr(4'd10, 16'h1234);
    rd(4'd10);
    check("commit_pending_rd", NR*DW'(rd_data), NR*DW'(1));
    frame_end(1);
    check("commit_shadow_p1x", NR*DW'(shadow_flat[P1_X*DW +: DW]), NR*DW'(16'h0050));
    rd(4'd10);
    check("commit_cleared_rd", NR*DW'(rd_data), NR*DW'(0));
    check("commit_no_err", NR*DW'(addr_err), NR*DW'(0));
    // Commit written on the swap edge itself.
    step(0, 1, 0, 4'd10, 16'h0001, 1, LAST);
    check("commit_same_edge_fswap", NR*DW'(frame_swap), NR*DW'(1));
    idle();
`else
    // Qualified frame end swaps; unqualified does not.
    frame_end(1);
    check("swap_ball_x", NR*DW'(shadow_flat[BALL_X*DW +: DW]), NR*DW'(16'h0123));
    check("swap_count", NR*DW'(frame_count), NR*DW'(1));
    idle();
    frame_end(0);
    check("noready_count", NR*DW'(frame_count), NR*DW'(1));
    // Write on the swap edge: shadow gets the old value this frame.
    step(0, 1, 0, 4'(BALL_Y), 16'h00AA, 1, LAST);
    check("coincide_old", NR*DW'(shadow_flat[BALL_Y*DW +: DW]), NR*DW'(240));
    idle();
    frame_end(1);
    check("coincide_new", NR*DW'(shadow_flat[BALL_Y*DW +: DW]), NR*DW'(16'h00AA));
    // Back-to-back qualifying cycles each swap.
    frame_end(1);
    frame_end(1);
    check("b2b_count", NR*DW'(frame_count), NR*DW'(5));
    idle();
`endif

    // Unmapped address 0xB: write dropped, read yields zero with valid.
    wr(4'hB, 16'hDEAD);
    check("unmapped_wr_err", NR*DW'(addr_err), NR*DW'(1));
    rd(4'hB);
    check("unmapped_rd_data", NR*DW'(rd_data), NR*DW'(0));
    check("unmapped_rd_valid", NR*DW'(rd_valid), NR*DW'(1));
    idle();
    for (int i = 0; i < NR; i++) rd(4'(i));

    // Randomized traffic with occasional resets and frame ends.
    for (int n = 0; n < 1500; n++) begin
      bit r, c, rd_i, v;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [PW-1:0] p;
      r    = ($urandom_range(0, 99) == 0);
      c    = ($urandom_range(0, 3) != 0);
      rd_i = $urandom_range(0, 1) == 1;
      a    = AW'($urandom_range(0, 15));
      d    = DW'($urandom);
      v    = ($urandom_range(0, 3) != 0);
      p    = ($urandom_range(0, 4) == 0) ? LAST : PW'($urandom_range(0, 32'h4AFFF));
      step(r, c, rd_i, a, d, v, p);
    end
    // Final sweep of every address, including the commit/unmapped ones.
    for (int i = 0; i < 16; i++) rd(4'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
